// File: rtl/secuenciador_suma_serie.sv
// Serial multi-word adder: one shared 4-bit ripple adder walks the operands
// a nibble per clock, carrying between cycles through a register.

// 4-bit ripple-carry adder, shared datapath slice.
module sumador4b_verilog (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[4];
endmodule

module secuenciador_suma_serie #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 Ci,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES:0]   Y,
  output logic                 Co
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  a_sh, b_sh;
  logic          carry;
  logic [IW-1:0] idx;
  logic          last;
  logic [3:0]    sum;
  logic          cout;

  assign last = (idx == IW'(NIBBLES - 1));

  sumador4b_verilog u_add (
    .a  (a_sh[3:0]),
    .b  (b_sh[3:0]),
    .ci (carry),
    .s  (sum),
    .co (cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: RUN lasts exactly NIBBLES cycles, DONE one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs; done pulses on the DONE->IDLE edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      Y     <= '0;
      Co    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= Ci;
            idx   <= '0;
            Y     <= '0;
            Co    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++)
            if (idx == IW'(i)) Y[4*i +: 4] <= sum;
          carry <= cout;
          a_sh  <= a_sh >> 4;
          b_sh  <= b_sh >> 4;
          idx   <= idx + 1'b1;
          if (last) begin
            Y[W] <= cout;
            Co   <= cout;
            busy <= 1'b0;
          end
        end
        DONE: done <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule
